// File: rtl/prog_sequencer.sv
// Program sequencer: holds a small writable program memory and feeds it to the CPU
// one instruction at a time over the load/start/wait handshake, capturing the
// CPU output and N/V/Z flags after each instruction.
// Optional watchdog on the wait phases is built when SEQ_TIMEOUT_EN is defined.
module prog_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W:0]   count,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_wdata,
  output logic [15:0]       cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  input  logic [15:0]       cpu_out,
  input  logic              cpu_N,
  input  logic              cpu_V,
  input  logic              cpu_Z,
  output logic [15:0]       result,
  output logic [2:0]        flags,
  output logic [ADDR_W:0]   pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StReady, StLoad, StStart, StWaitLo, StWaitHi, StCapt, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         mem_q [Depth];
  logic [15:0]         cpu_in_q, cpu_in_d;
  logic [15:0]         result_q, result_d;
  logic [2:0]          flags_q, flags_d;
  logic [ADDR_W:0]     pc_q, pc_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                timeout;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Watchdog counter: restarts on every entry to a wait state, idles at zero elsewhere
  always_comb begin
    cnt_d = '0;
    if ((state_q == StWaitLo || state_q == StWaitHi) && state_d == state_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q;
    if (state_q == StIdle && go) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Expires only when the wait state's exit condition has not been met this cycle
  assign timeout = ((state_q == StWaitLo && cpu_w) || (state_q == StWaitHi && !cpu_w)) &&
                   (cnt_q == CntW'(TIMEOUT - 1));
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Program memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (state_q == StIdle && prog_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cpu_in_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      pc_q     <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cpu_in_q <= cpu_in_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (go) state_d = (count == '0) ? StDone : StReady;
      StReady:  if (cpu_w) state_d = StLoad;
      StLoad:   state_d = StStart;
      StStart:  state_d = StWaitLo;
      StWaitLo: if (!cpu_w) state_d = StWaitHi;
                else if (timeout) state_d = StDone;
      StWaitHi: if (cpu_w) state_d = StCapt;
                else if (timeout) state_d = StDone;
      StCapt:   state_d = ((pc_q + 1'b1) == count_q) ? StDone : StReady;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state: run setup, fetch and capture
  always_comb begin
    cpu_in_d = cpu_in_q;
    result_d = result_q;
    flags_d  = flags_q;
    pc_d     = pc_q;
    count_d  = count_q;
    if (state_q == StIdle && go) begin
      count_d = count;
      pc_d    = '0;
    end
    if (state_q == StReady && cpu_w) begin
      cpu_in_d = mem_q[pc_q[ADDR_W-1:0]];
    end
    if (state_q == StCapt) begin
      result_d = cpu_out;
      flags_d  = {cpu_N, cpu_V, cpu_Z};
      pc_d     = pc_q + 1'b1;
    end
  end

  // Moore outputs decoded from state
  always_comb begin
    cpu_load = (state_q == StLoad);
    cpu_s    = (state_q == StStart);
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
  end

  assign cpu_in = cpu_in_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign pc     = pc_q;

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer that drives the CPU's instruction handshake from the initiator side. It holds a small writable program memory and, on `go`, feeds instructions one at a time. For each instruction it presents the word on `cpu_in`, pulses `cpu_load`, pulses `cpu_s`, waits for the CPU's `cpu_w` to drop and return, then captures `cpu_out` and the N/V/Z flags. It sits between the lab bench/top level (switches, loader) and the `cpu` block.

## Interface
- `ADDR_W`, 4: program memory address width; depth = 2^ADDR_W words of 16 bits.
- `TIMEOUT`, 255: watchdog limit in cycles per wait phase; only used with `SEQ_TIMEOUT_EN`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `go` input 1: start a run, sampled in IDLE only.
- `count` input ADDR_W+1: number of instructions to execute, 0..2^ADDR_W; sampled with `go`.
- `prog_we` input 1: program memory write enable; honoured in IDLE only.
- `prog_addr` input ADDR_W: program memory write address.
- `prog_wdata` input 16: program memory write data.
- `cpu_in` output 16: instruction word to the CPU; registered.
- `cpu_load` output 1: one-cycle instruction-register load strobe.
- `cpu_s` output 1: one-cycle start strobe.
- `cpu_w` input 1: CPU waiting/ready flag.
- `cpu_out` input 16: CPU datapath output.
- `cpu_N`, `cpu_V`, `cpu_Z` input 1 each: CPU status flags.
- `result` output 16: `cpu_out` captured after the last completed instruction.
- `flags` output 3: {N,V,Z} captured with `result`.
- `pc` output ADDR_W+1: index of the current or next instruction.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at the end of a run.
- `err` output 1: sticky watchdog error; cleared by `reset` or by an accepted `go`.

## Operation
- States: IDLE, READY, LOAD, START, WAITLO, WAITHI, CAPT, DONE.
- IDLE:
  - `prog_we` writes `mem[prog_addr]`.
  - On `go`: latch `count`, set `pc`=0, clear `err`. Next state is DONE if `count`==0, otherwise READY.
- READY: wait for `cpu_w`=1. On that cycle, register `cpu_in`←`mem[pc]` and go to LOAD.
- LOAD: `cpu_load`=1 for this cycle only; go to START.
- START: `cpu_s`=1 for this cycle only; go to WAITLO.
- WAITLO: wait for `cpu_w`=0, then go to WAITHI.
- WAITHI: wait for `cpu_w`=1, then go to CAPT.
- CAPT:
  - `result`←`cpu_out`; `flags`←{`cpu_N`,`cpu_V`,`cpu_Z`}; `pc`←`pc`+1.
  - Next state is DONE if `pc`+1==`count`, otherwise READY.
- DONE: `done`=1 for one cycle; go to IDLE.
- `cpu_in` holds its value from READY until the next READY capture, so it is stable across `cpu_load`.
- `go` outside IDLE: ignored.
- `prog_we` outside IDLE: ignored; memory is unchanged.
- `go` and `prog_we` in the same IDLE cycle: the write completes and the run starts. The first fetch is at least one cycle later and sees the new word.
- `pc` arithmetic is unsigned, width ADDR_W+1, so `count`=2^ADDR_W runs the full memory without wrap. Memory reads use `pc[ADDR_W-1:0]`.
- Reset (at any time, including mid-run):
  - state→IDLE.
  - `pc`, `cpu_in`, `result`, `flags` → 0.
  - `cpu_load`, `cpu_s`, `busy`, `done`, `err` → 0.
  - Memory contents are not reset.

## Timing
- `go` accepted at edge t → READY at t+1. Fetch occurs at the earliest cycle with `cpu_w`=1.
- Minimum per-instruction cost, with the CPU returning `w` immediately:
  - READY→LOAD→START→WAITLO→WAITHI→CAPT = 6 cycles, plus CPU execution cycles.
- `cpu_load` and `cpu_s` are never high in the same cycle. `cpu_s` always follows `cpu_load` by exactly one cycle.
- `result` and `flags` update on the edge leaving CAPT. `done` rises on the edge after the final CAPT.
- `count`=0: `done` pulses at t+1. `result` is unchanged and `busy` is high for that one cycle.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAITLO and in WAITHI, reset on entry to each.
  - If the counter reaches `TIMEOUT` before the exit condition, set `err`=1 and go to DONE; `done` still pulses.
  - `result` and `pc` keep the values of the last good instruction.
- `SEQ_TIMEOUT_EN` undefined: no counter is built, `err` is tied to 0, and the wait states wait indefinitely.

## Test plan
- Load `mem[0..2]` = 0xD007 (MOV R0,#7), 0xD102 (MOV R1,#2), 0xA140 (ADD R2,R1,R0); `go` with `count`=3 against the real `cpu`. Required: `done` pulse, `result`=9, `flags`=3'b000, `pc`=3, `err`=0.
- Same program followed by CMP R0,R0 (0xA800) with `count`=4. Required: `flags`[0] (Z)=1 and `result`=0.
- Mock CPU holding `cpu_w`=0 in READY for 10 cycles. Required: no `cpu_load` until the cycle after `cpu_w`=1; `cpu_in` stable through `cpu_load` and `cpu_s`; `cpu_s` exactly one cycle after `cpu_load`.
- `go` with `count`=0. Required: `done` at t+1 with no `cpu_load`. Separately, `prog_we` while `busy`: the memory word is unchanged after the run.
- Assert `reset` during WAITHI. Required: next cycle in IDLE with all outputs 0; a fresh `go` reruns from `pc`=0 with memory intact.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT`=20, a mock that never drops `cpu_w` after `cpu_s`. Required: `err`=1 and a `done` pulse 21 cycles after START. A following `go` clears `err`.
